// File: rtl/systolic_feeder_ctrl_if.sv
// systolic_feeder_ctrl_if: control, operand-buffer, array-edge and result handshake bundle
interface systolic_feeder_ctrl_if #(
  parameter int N = 4,
  parameter int DATA_W = 16,
  parameter int AW = 8
);
  logic start;
  logic [AW:0] k_len;
  logic busy;
  logic done;
  logic a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic [N*DATA_W-1:0] a_rd_data;
  logic b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [N*DATA_W-1:0] b_rd_data;
  logic arr_en;
  logic [N*DATA_W-1:0] a_west;
  logic [N-1:0] a_valid;
  logic [N-1:0] a_ready;
  logic [N*DATA_W-1:0] b_north;
  logic [N-1:0] b_valid;
  logic [N-1:0] b_ready;
  logic [N-1:0] c_valid;
  logic [N-1:0] c_ready;
  modport master (
    input start, k_len, a_rd_data, b_rd_data, a_ready, b_ready, c_valid,
    output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_en,
    output a_west, a_valid, b_north, b_valid, c_ready
  );
  modport slave (
    output start, k_len, a_rd_data, b_rd_data, a_ready, b_ready, c_valid,
    input busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, arr_en,
    input a_west, a_valid, b_north, b_valid, c_ready
  );
endinterface

// File: rtl/systolic_feeder_ctrl.sv
// systolic_feeder_ctrl: streams A columns / B rows into an N x N array with per-lane skew and counts results
module systolic_feeder_ctrl #(
  parameter int N = 4,
  parameter int DATA_W = 16,
  parameter int AW = 8
) (
  input logic clk,
  input logic rst,
  systolic_feeder_ctrl_if.master io
);
  localparam int W = N * DATA_W;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [AW-1:0] k;
  logic [AW:0] len;
  logic p, hv, v0, stall, issue, last, empty, full, go;
  logic [W-1:0] ha, hb, a0, b0;
  logic [N-2:0] sv;
  logic [CW-1:0] cnt [N];
  logic [N-1:0] acc;
  assign go = state == IDLE && io.start;
  // Read data is shown straight from the buffer; a hold register keeps it if a stall hits that cycle
  assign v0 = p | hv;
  assign a0 = hv ? ha : p ? io.a_rd_data : '0;
  assign b0 = hv ? hb : p ? io.b_rd_data : '0;
  assign stall = |((io.a_valid & ~io.a_ready) | (io.b_valid & ~io.b_ready));
  assign issue = state == FEED && !stall;
  assign last = {1'b0, k} == len - 1'b1;
  assign empty = !v0 && sv == '0;
  assign acc = io.c_valid & io.c_ready;
  assign io.busy = state != IDLE;
  assign io.arr_en = state != IDLE;
  assign io.done = state == DONE;
  assign io.a_rd_en = issue;
  assign io.b_rd_en = issue;
  assign io.a_rd_addr = k;
  assign io.b_rd_addr = k;
  assign io.c_ready = {N{state inside {FEED, FLUSH, DRAIN}}};
  assign io.a_valid = {sv, v0};
  assign io.b_valid = {sv, v0};
  // Counts the current cycle's acceptance so DONE follows the last result by one edge
  always_comb begin
    full = 1'b1;
    for (int j = 0; j < N; j++) full &= cnt[j] == CW'(N) || (cnt[j] == CW'(N - 1) && acc[j]);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !io.start ? IDLE : io.k_len == '0 ? DONE : FEED;
      FEED: nxt = issue && last ? FLUSH : FEED;
      FLUSH: nxt = empty ? DRAIN : FLUSH;
      DRAIN: nxt = full ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k <= '0;
      len <= '0;
      p <= 1'b0;
      hv <= 1'b0;
      ha <= '0;
      hb <= '0;
      sv <= '0;
      for (int j = 0; j < N; j++) cnt[j] <= '0;
    end else if (go) begin
      k <= '0;
      len <= io.k_len;
      p <= 1'b0;
      hv <= 1'b0;
      ha <= '0;
      hb <= '0;
      sv <= '0;
      for (int j = 0; j < N; j++) cnt[j] <= '0;
    end else begin
      if (issue) k <= k + 1'b1;
      p <= issue;
      hv <= stall & v0;
      if (stall) begin
        ha <= a0;
        hb <= b0;
      end else sv <= (N-1)'({sv, v0});
      for (int j = 0; j < N; j++) if (acc[j] && cnt[j] != CW'(N)) cnt[j] <= cnt[j] + 1'b1;
    end
  for (genvar i = 0; i < N; i++) begin : g
    if (i == 0) begin : l0
      assign io.a_west[DATA_W-1:0] = a0[DATA_W-1:0];
      assign io.b_north[DATA_W-1:0] = b0[DATA_W-1:0];
    end else begin : ln
      logic [i*DATA_W-1:0] ra, rb;
      always_ff @(posedge clk or posedge rst)
        if (rst || go) begin
          ra <= '0;
          rb <= '0;
        end else if (!stall) begin
          ra <= (i*DATA_W)'({ra, a0[i*DATA_W +: DATA_W]});
          rb <= (i*DATA_W)'({rb, b0[i*DATA_W +: DATA_W]});
        end
      assign io.a_west[i*DATA_W +: DATA_W] = ra[i*DATA_W-1 -: DATA_W];
      assign io.b_north[i*DATA_W +: DATA_W] = rb[i*DATA_W-1 -: DATA_W];
    end
  end
endmodule

// File: tb/tb_systolic_feeder_ctrl.sv
// tb_systolic_feeder_ctrl: directed checks of skewed feeding, stalls, result drain and reset abort
module tb_systolic_feeder_ctrl;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_en = 1'b0;
  logic clr = 1'b0;
  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int fails = 0;
  int ccnt [N];
  int acc_tot;
  int rd_n, rd_first, rd_last, seq_err, done_n, done_cyc;
  int vfirst [N];
  int vlast [N];
  int an [N];
  int bn [N];
  always #5 clk = ~clk;
  systolic_feeder_ctrl_if #(.N(N), .DATA_W(DW), .AW(AW)) io ();
  systolic_feeder_ctrl #(.N(N), .DATA_W(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .io(io));
  function automatic logic [N*DW-1:0] word(input logic [3:0] tag, input logic [AW-1:0] a);
    for (int i = 0; i < N; i++) word[i*DW +: DW] = {tag, 4'(i), a};
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // Buffers return garbage when not read so lost read data would show up
  always @(posedge clk) begin
    io.a_rd_data <= io.a_rd_en ? word(4'hA, io.a_rd_addr) : {$urandom, $urandom};
    io.b_rd_data <= io.b_rd_en ? word(4'hB, io.b_rd_addr) : {$urandom, $urandom};
  end
  always_comb for (int j = 0; j < N; j++) io.c_valid[j] = c_en && ccnt[j] < N;
  always @(posedge clk)
    if (clr) begin
      for (int j = 0; j < N; j++) ccnt[j] <= 0;
      acc_tot <= 0;
    end else begin
      for (int j = 0; j < N; j++) if (io.c_valid[j] && io.c_ready[j]) ccnt[j] <= ccnt[j] + 1;
      acc_tot <= acc_tot + $countones(io.c_valid & io.c_ready);
    end
  // An operand moves on a lane only when that lane handshakes and no lane anywhere is stalled
  always @(negedge clk) begin : rec
    int r;
    logic stl;
    logic [DW-1:0] la, lb;
    r = cyc - t0 + 1;
    if (clr) begin
      rd_n = 0; rd_first = -1; rd_last = -1; seq_err = 0; done_n = 0; done_cyc = -1;
      for (int i = 0; i < N; i++) begin vfirst[i] = -1; vlast[i] = -1; an[i] = 0; bn[i] = 0; end
    end else begin
      if (io.a_rd_en) begin
        if (rd_n == 0) rd_first = r;
        rd_last = r;
        if (io.a_rd_addr != AW'(rd_n) || io.b_rd_addr != io.a_rd_addr || !io.b_rd_en) seq_err++;
        rd_n++;
      end
      if (io.done) begin done_n++; done_cyc = r; end
      stl = |((io.a_valid & ~io.a_ready) | (io.b_valid & ~io.b_ready));
      for (int i = 0; i < N; i++) begin
        la = io.a_west[i*DW +: DW];
        lb = io.b_north[i*DW +: DW];
        if (io.a_valid[i]) begin
          if (vfirst[i] < 0) vfirst[i] = r;
          vlast[i] = r;
        end
        if ((!io.a_valid[i] && la != 0) || (!io.b_valid[i] && lb != 0)) seq_err++;
        if (io.a_valid[i] && io.a_ready[i] && !stl) begin
          if (la != {4'hA, 4'(i), 8'(an[i])}) seq_err++;
          an[i]++;
        end
        if (io.b_valid[i] && io.b_ready[i] && !stl) begin
          if (lb != {4'hB, 4'(i), 8'(bn[i])}) seq_err++;
          bn[i]++;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go_cyc(input int r);
    while (cyc < t0 + r - 1) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start_pass(input int kl);
    @(posedge clk);
    #1;
    clr = 1'b1;
    io.start = 1'b1;
    io.k_len = 9'(kl);
    @(posedge clk);
    #1;
    clr = 1'b0;
    io.start = 1'b0;
    t0 = cyc;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(io.busy), 0);
    chk({tag, "_done"}, 64'(io.done), 0);
    chk({tag, "_arr_en"}, 64'(io.arr_en), 0);
    chk({tag, "_rd_en"}, 64'({io.a_rd_en, io.b_rd_en}), 0);
    chk({tag, "_addr"}, 64'({io.a_rd_addr, io.b_rd_addr}), 0);
    chk({tag, "_valid"}, 64'({io.a_valid, io.b_valid}), 0);
    chk({tag, "_a_west"}, io.a_west, 0);
    chk({tag, "_b_north"}, io.b_north, 0);
    chk({tag, "_c_ready"}, 64'(io.c_ready), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    io.start = 1'b0;
    io.k_len = '0;
    io.a_ready = '1;
    io.b_ready = '1;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;
    // basic pass, k_len=4
    c_en = 1'b1;
    start_pass(4);
    go_cyc(2);
    @(negedge clk);
    chk("t1_c_ready_feed", 64'(io.c_ready), 64'hF);
    chk("t1_arr_en_feed", 64'(io.arr_en), 1);
    go_cyc(11);
    @(negedge clk);
    chk("t1_done_c11", 64'(io.done), 1);
    go_cyc(12);
    @(negedge clk);
    chk("t1_busy_c12", 64'(io.busy), 0);
    chk("t1_rd_n", 64'(rd_n), 4);
    chk("t1_rd_first", 64'(rd_first), 1);
    chk("t1_rd_last", 64'(rd_last), 4);
    chk("t1_l0_first", 64'(vfirst[0]), 2);
    chk("t1_l0_last", 64'(vlast[0]), 5);
    chk("t1_l3_first", 64'(vfirst[3]), 5);
    chk("t1_l3_last", 64'(vlast[3]), 8);
    chk("t1_done_n", 64'(done_n), 1);
    chk("t1_seq_err", 64'(seq_err), 0);
    chk("t1_b3_count", 64'(bn[3]), 4);
    // zero-length pass
    start_pass(0);
    go_cyc(1);
    @(negedge clk);
    chk("t2_done_c1", 64'(io.done), 1);
    chk("t2_busy_c1", 64'(io.busy), 1);
    go_cyc(3);
    @(negedge clk);
    chk("t2_busy_c3", 64'(io.busy), 0);
    chk("t2_rd_n", 64'(rd_n), 0);
    chk("t2_no_valid", 64'(vfirst[0]), 64'(-1));
    chk("t2_done_n", 64'(done_n), 1);
    // lane 2 back-pressure for three cycles mid-FEED
    start_pass(8);
    go_cyc(5);
    io.a_ready[2] = 1'b0;
    go_cyc(8);
    io.a_ready[2] = 1'b1;
    go_cyc(20);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t3_a_lane%0d_count", i), 64'(an[i]), 8);
      chk($sformatf("t3_b_lane%0d_count", i), 64'(bn[i]), 8);
    end
    chk("t3_rd_n", 64'(rd_n), 8);
    chk("t3_seq_err", 64'(seq_err), 0);
    chk("t3_done_cyc", 64'(done_cyc), 18);
    chk("t3_done_n", 64'(done_n), 1);
    // start re-pulsed while busy, in FEED and in DONE
    start_pass(4);
    go_cyc(3);
    io.start = 1'b1;
    io.k_len = 9'd6;
    go_cyc(4);
    io.start = 1'b0;
    go_cyc(11);
    io.start = 1'b1;
    go_cyc(12);
    io.start = 1'b0;
    go_cyc(14);
    @(negedge clk);
    chk("t4_busy", 64'(io.busy), 0);
    chk("t4_rd_n", 64'(rd_n), 4);
    chk("t4_seq_err", 64'(seq_err), 0);
    chk("t4_done_n", 64'(done_n), 1);
    chk("t4_done_cyc", 64'(done_cyc), 11);
    // reset during FLUSH aborts, then a clean pass
    start_pass(4);
    go_cyc(7);
    rst = 1'b1;
    #1;
    chk_idle_outputs("t5_abort");
    go_cyc(9);
    rst = 1'b0;
    chk("t5_no_done", 64'(done_n), 0);
    start_pass(4);
    go_cyc(13);
    @(negedge clk);
    chk("t5_done_cyc", 64'(done_cyc), 11);
    chk("t5_done_n", 64'(done_n), 1);
    chk("t5_a3_count", 64'(an[3]), 4);
    chk("t5_seq_err", 64'(seq_err), 0);
    // results withheld until 20 cycles into FLUSH/DRAIN
    c_en = 1'b0;
    start_pass(4);
    go_cyc(24);
    @(negedge clk);
    chk("t6_busy_wait", 64'(io.busy), 1);
    chk("t6_no_done_wait", 64'(done_n), 0);
    go_cyc(25);
    c_en = 1'b1;
    go_cyc(31);
    @(negedge clk);
    chk("t6_done_cyc", 64'(done_cyc), 29);
    chk("t6_done_n", 64'(done_n), 1);
    chk("t6_accepted", 64'(acc_tot), 16);
    chk("t6_busy_end", 64'(io.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
